// File: rtl/axis_bf_pkg.sv
// Constants shared by the beamforming datapath blocks.
package axis_bf_pkg;

    localparam int BF_SAMPLES      = 16;
    localparam int BF_PROD_WIDTH   = 16;
    localparam int BF_SAMPLE_WIDTH = 8;
    localparam int BF_WEIGHT_FRAC  = 7;

endpackage

// File: rtl/requant_lane.sv
// One lane: round-half-up, arithmetic right shift and saturate a signed product.
module requant_lane #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SHIFT = 7
) (
    input  logic [IN_W-1:0]  p,
    output logic [OUT_W-1:0] q,
    output logic             sat
);

    localparam logic signed [IN_W:0] RND   = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0] MAX_Q = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] MIN_Q = (IN_W+1)'(-(2 ** (OUT_W - 1)));

    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] sh;
    logic                 over;
    logic                 under;

    // One guard bit keeps p + RND from overflowing for the largest positive product.
    always_comb begin
        sum   = $signed({p[IN_W-1], p}) + RND;
        sh    = sum >>> SHIFT;
        over  = sh > MAX_Q;
        under = sh < MIN_Q;
        sat   = over || under;
        if (over)
            q = MAX_Q[OUT_W-1:0];
        else if (under)
            q = MIN_Q[OUT_W-1:0];
        else
            q = sh[OUT_W-1:0];
    end

endmodule

// File: rtl/axis_requantizer.sv
// Requantizes 16-bit beamformer products to 8 bits per lane behind a 2-entry AXIS skid,
// with saturation and frame statistics.
module axis_requantizer
    import axis_bf_pkg::*;
#(
    parameter int SAMPLES          = BF_SAMPLES,
    parameter int IN_SAMPLE_WIDTH  = BF_PROD_WIDTH,
    parameter int OUT_SAMPLE_WIDTH = BF_SAMPLE_WIDTH,
    parameter int SHIFT            = BF_WEIGHT_FRAC,
    parameter int CNT_WIDTH        = 32
) (
    input  logic                                  CLK,
    input  logic                                  resetn,
    input  logic [SAMPLES*IN_SAMPLE_WIDTH-1:0]    s_axis_tdata,
    input  logic [SAMPLES-1:0]                    s_axis_tkeep,
    input  logic                                  s_axis_tvalid,
    input  logic                                  s_axis_tlast,
    output logic                                  s_axis_tready,
    output logic [SAMPLES*OUT_SAMPLE_WIDTH-1:0]   m_axis_tdata,
    output logic [SAMPLES-1:0]                    m_axis_tkeep,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_tready,
    input  logic                                  clr_stats,
    output logic [CNT_WIDTH-1:0]                  sat_count,
    output logic                                  sat_flag,
    output logic [15:0]                           frame_count
);

    localparam int OW = SAMPLES * OUT_SAMPLE_WIDTH;

    logic [OW-1:0]      lane_q;
    logic [SAMPLES-1:0] lane_sat;
    logic               sat_any;

    for (genvar i = 0; i < SAMPLES; i++) begin : g_lane
        requant_lane #(
            .IN_W (IN_SAMPLE_WIDTH),
            .OUT_W(OUT_SAMPLE_WIDTH),
            .SHIFT(SHIFT)
        ) u_lane (
            .p  (s_axis_tdata[i*IN_SAMPLE_WIDTH +: IN_SAMPLE_WIDTH]),
            .q  (lane_q[i*OUT_SAMPLE_WIDTH +: OUT_SAMPLE_WIDTH]),
            .sat(lane_sat[i])
        );
    end

    assign sat_any = |(lane_sat & s_axis_tkeep);

    // Handshake: a transfer happens on a clock edge where valid && ready are both high;
    // valid never depends on ready, and payload holds until the transfer.
    logic          accept;
    logic          drain;
    logic          skid_valid;
    logic          skid_next;
    logic [OW-1:0] skid_data;
    logic [SAMPLES-1:0] skid_keep;
    logic          skid_last;

    assign accept = s_axis_tvalid && s_axis_tready;
    assign drain  = m_axis_tvalid && m_axis_tready;

    always_comb begin
        skid_next = 1'b0;
        if (skid_valid)
            skid_next = !drain;
        else
            skid_next = accept && m_axis_tvalid && !m_axis_tready;
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            skid_valid    <= 1'b0;
            skid_data     <= '0;
            skid_keep     <= '0;
            skid_last     <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            if (skid_valid) begin
                if (drain) begin
                    m_axis_tdata <= skid_data;
                    m_axis_tkeep <= skid_keep;
                    m_axis_tlast <= skid_last;
                    skid_valid   <= 1'b0;
                end
            end else if (accept) begin
                if (!m_axis_tvalid || m_axis_tready) begin
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= lane_q;
                    m_axis_tkeep  <= s_axis_tkeep;
                    m_axis_tlast  <= s_axis_tlast;
                end else begin
                    skid_valid <= 1'b1;
                    skid_data  <= lane_q;
                    skid_keep  <= s_axis_tkeep;
                    skid_last  <= s_axis_tlast;
                end
            end else if (drain) begin
                m_axis_tvalid <= 1'b0;
            end
            s_axis_tready <= !skid_next;
        end
    end

    // Clear has priority over any statistic event in the same cycle.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            sat_count   <= '0;
            sat_flag    <= 1'b0;
            frame_count <= '0;
        end else if (clr_stats) begin
            sat_count   <= '0;
            sat_flag    <= 1'b0;
            frame_count <= '0;
        end else if (accept) begin
            if (sat_any) begin
                sat_flag <= 1'b1;
                if (sat_count != {CNT_WIDTH{1'b1}})
                    sat_count <= sat_count + 1'b1;
            end
            if (s_axis_tlast)
                frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_axis_requantizer.sv
// Bench for axis_requantizer: directed vector table, scoreboard on every output beat,
// and hand-written stall, frame/clear and async-reset sequences.
module tb_axis_requantizer;

    logic         CLK = 1'b0;
    logic         resetn = 1'b1;
    logic [255:0] s_axis_tdata;
    logic [15:0]  s_axis_tkeep;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tready;
    logic [127:0] m_axis_tdata;
    logic [15:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready;
    logic         clr_stats;
    logic [31:0]  sat_count;
    logic         sat_flag;
    logic [15:0]  frame_count;

    axis_requantizer dut (
        .CLK          (CLK),
        .resetn       (resetn),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tready(m_axis_tready),
        .clr_stats    (clr_stats),
        .sat_count    (sat_count),
        .sat_flag     (sat_flag),
        .frame_count  (frame_count)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int out_hs = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    logic [144:0] exp_q[$];

    typedef struct {
        logic [255:0] data;
        logic [15:0]  keep;
        logic         last;
        logic [127:0] exp_data;
        logic [31:0]  exp_sat;
    } vec_t;
    vec_t vecs[7];

    // Reference: floor((p + 64) / 128) clamped to the signed 8-bit range.
    function automatic logic [144:0] model(logic [255:0] d, logic [15:0] k, logic l);
        logic [127:0] q;
        int p;
        int r;
        q = '0;
        for (int i = 0; i < 16; i++) begin
            p = int'($signed(d[i*16 +: 16]));
            r = (p + 64) >>> 7;
            if (r > 127) r = 127;
            else if (r < -128) r = -128;
            q[i*8 +: 8] = r[7:0];
        end
        return {l, k, q};
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send(input logic [255:0] d, input logic [15:0] k, input logic l);
        int budget;
        budget = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        forever begin
            @(negedge CLK);
            if (s_axis_tready) break;
            budget++;
            if (budget > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: got tready 0 expected 1 within 200 cycles");
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [255:0] rand_beat();
        logic [255:0] d;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
        return d;
    endfunction

    // Scoreboard: pop/compare on each output transfer, push on each input transfer.
    always @(negedge CLK) begin
        logic [144:0] e;
        cyc++;
        if (resetn) begin
            if (m_axis_tvalid && m_axis_tready) begin
                out_hs++;
                if (out_hs == 1) first_cyc = cyc;
                last_cyc = cyc;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got beat %0h expected none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_axis_tlast, m_axis_tkeep, m_axis_tdata} !== e) begin
                        n_fail++;
                        $display("FAIL sb_beat: got %0h expected %0h",
                                 {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, e);
                    end
                end
            end
            if (s_axis_tvalid && s_axis_tready)
                exp_q.push_back(model(s_axis_tdata, s_axis_tkeep, s_axis_tlast));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] sd[3];
        logic [144:0] exp_a;
        logic         hs;
        int           acc;
        int           start_cyc;

        for (int v = 0; v < 7; v++) begin
            vecs[v].data = '0;
            vecs[v].keep = 16'hFFFF;
            vecs[v].last = 1'b0;
        end
        vecs[0].data[15:0] = 16'h0040; vecs[0].data[31:16] = 16'hFFC0;
        vecs[0].data[47:32] = 16'h0000; vecs[0].data[63:48] = 16'h003F;
        vecs[0].exp_data = 128'h01; vecs[0].exp_sat = 0;
        vecs[1].data[15:0] = 16'h3FFF; vecs[1].data[31:16] = 16'h8000;
        vecs[1].exp_data = 128'h807F; vecs[1].exp_sat = 1;
        vecs[2].data = vecs[1].data; vecs[2].keep = 16'hFFFC; vecs[2].last = 1'b1;
        vecs[2].exp_data = 128'h807F; vecs[2].exp_sat = 1;
        vecs[3].data[47:32] = 16'hFF00; vecs[3].data[63:48] = 16'h3F40;
        vecs[3].exp_data = 128'h7FFE0000; vecs[3].exp_sat = 1;
        vecs[4].data[255:240] = 16'hC000; vecs[4].data[239:224] = 16'hBFC0;
        vecs[4].exp_data = 128'h8080_0000_0000_0000_0000_0000_0000_0000; vecs[4].exp_sat = 1;
        vecs[5].data[223:208] = 16'hBFBF; vecs[5].data[15:0] = 16'h7FFF;
        vecs[5].exp_data = 128'h0000_8000_0000_0000_0000_0000_0000_007F; vecs[5].exp_sat = 2;
        vecs[6].data[95:80] = 16'h4000; vecs[6].keep = 16'hFFDF;
        vecs[6].exp_data = 128'h0000_0000_0000_0000_0000_7F00_0000_0000; vecs[6].exp_sat = 2;

        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b1; clr_stats = 1'b0;

        // Power-up reset
        #1 resetn = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_stats", {sat_count, sat_flag, frame_count}, 0);
        @(posedge CLK); #1 resetn = 1'b1;
        @(negedge CLK);
        chk("rdy_before_edge", s_axis_tready, 0);
        @(negedge CLK);
        chk("rdy_after_edge", s_axis_tready, 1);
        @(posedge CLK); #1;

        // Directed vector table, one beat at a time
        for (int v = 0; v < 7; v++) begin
            send(vecs[v].data, vecs[v].keep, vecs[v].last);
            s_axis_tvalid = 1'b0;
            @(negedge CLK);
            chk("tbl_valid", m_axis_tvalid, 1);
            chk("tbl_data", m_axis_tdata, vecs[v].exp_data);
            chk("tbl_keep", m_axis_tkeep, vecs[v].keep);
            chk("tbl_last", m_axis_tlast, vecs[v].last);
            chk("tbl_sat_count", sat_count, vecs[v].exp_sat);
            @(posedge CLK); #1;
        end
        @(negedge CLK);
        chk("tbl_sat_flag", sat_flag, 1);
        chk("tbl_frame_count", frame_count, 1);
        @(posedge CLK); #1;

        // 64 back-to-back beats
        out_hs = 0;
        start_cyc = cyc;
        for (int i = 0; i < 64; i++) send(rand_beat(), 16'hFFFF, (i % 8) == 7);
        chk("b2b_in_cycles", cyc - start_cyc, 64);
        s_axis_tvalid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("b2b_out_count", out_hs, 64);
        chk("b2b_out_span", last_cyc - first_cyc, 63);
        @(posedge CLK); #1;

        // Downstream stall with upstream pushing
        for (int j = 0; j < 3; j++) sd[j] = rand_beat();
        exp_a = model(sd[0], 16'hFFFF, 1'b0);
        m_axis_tready = 1'b0;
        s_axis_tdata = sd[0]; s_axis_tkeep = 16'hFFFF; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (c >= 1) begin
                chk("stall_valid", m_axis_tvalid, 1);
                chk("stall_data", m_axis_tdata, exp_a[127:0]);
            end
            if (c >= 2) chk("stall_ready_low", s_axis_tready, 0);
            hs = s_axis_tready;
            @(posedge CLK); #1;
            if (hs) begin
                acc++;
                if (acc < 3) s_axis_tdata = sd[acc];
            end
        end
        s_axis_tvalid = 1'b0;
        chk("stall_accepts", acc, 2);
        m_axis_tready = 1'b1;
        repeat (4) @(negedge CLK);
        chk("stall_drained", exp_q.size(), 0);
        chk("stall_ready_back", s_axis_tready, 1);
        @(posedge CLK); #1;

        // Frames and clear
        clr_stats = 1'b1;
        @(posedge CLK); #1 clr_stats = 1'b0;
        @(negedge CLK);
        chk("clr_stats_zero", {sat_count, sat_flag, frame_count}, 0);
        @(posedge CLK); #1;
        for (int i = 0; i < 12; i++) send(rand_beat(), 16'hFFFF, (i % 4) == 3);
        s_axis_tvalid = 1'b0;
        @(negedge CLK);
        chk("frame_count_3", frame_count, 3);
        chk("frame_sat_flag", sat_flag, 1);
        @(posedge CLK); #1;
        for (int i = 0; i < 3; i++) send(rand_beat(), 16'hFFFF, 1'b0);
        sd[0] = '0;
        sd[0][15:0] = 16'h8000;
        clr_stats = 1'b1;
        send(sd[0], 16'hFFFF, 1'b1);
        clr_stats = 1'b0;
        s_axis_tvalid = 1'b0;
        @(negedge CLK);
        chk("clr_wins_frame", frame_count, 0);
        chk("clr_wins_sat", {sat_count, sat_flag}, 0);
        @(posedge CLK); #1;

        // Async reset mid-frame with the skid full
        m_axis_tready = 1'b0;
        send(rand_beat(), 16'hFFFF, 1'b0);
        send(rand_beat(), 16'hFFFF, 1'b0);
        s_axis_tdata = rand_beat();
        @(negedge CLK);
        chk("skid_full_ready", s_axis_tready, 0);
        #2 resetn = 1'b0;
        #1;
        chk("arst_tvalid", m_axis_tvalid, 0);
        chk("arst_payload", {m_axis_tdata, m_axis_tkeep, m_axis_tlast}, 0);
        chk("arst_tready", s_axis_tready, 0);
        chk("arst_stats", {sat_count, sat_flag, frame_count}, 0);
        exp_q.delete();
        s_axis_tvalid = 1'b0;
        @(posedge CLK); #3 resetn = 1'b1;
        @(negedge CLK);
        chk("arst_rdy_before_edge", s_axis_tready, 0);
        @(negedge CLK);
        chk("arst_rdy_after_edge", s_axis_tready, 1);
        @(posedge CLK); #1;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 4; i++) send(rand_beat(), 16'hFFFF, i == 3);
        s_axis_tvalid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("post_rst_frame", frame_count, 1);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
